// File: rtl/axi_ahbl_single_bridge.sv
`default_nettype none
// ============================================================================
// Module      : axi_ahbl_single_bridge
// Description : AXI4 slave to AHB-Lite master bridge. Every AXI beat becomes
//               one AHB SINGLE NONSEQ transfer. Reads and writes are
//               serialised by round-robin arbitration, and AHB error
//               responses are folded into the AXI responses.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_ahbl_single_bridge #(
    parameter int          ID_W      = 4,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFFF
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic [ID_W-1:0] s_awid,
    input  logic [31:0]     s_awaddr,
    input  logic [7:0]      s_awlen,
    input  logic [2:0]      s_awsize,
    input  logic [1:0]      s_awburst,
    input  logic            s_awvalid,
    output logic            s_awready,
    input  logic [31:0]     s_wdata,
    input  logic [3:0]      s_wstrb,
    input  logic            s_wlast,
    input  logic            s_wvalid,
    output logic            s_wready,
    output logic [ID_W-1:0] s_bid,
    output logic [1:0]      s_bresp,
    output logic            s_bvalid,
    input  logic            s_bready,
    input  logic [ID_W-1:0] s_arid,
    input  logic [31:0]     s_araddr,
    input  logic [7:0]      s_arlen,
    input  logic [2:0]      s_arsize,
    input  logic [1:0]      s_arburst,
    input  logic            s_arvalid,
    output logic            s_arready,
    output logic [ID_W-1:0] s_rid,
    output logic [31:0]     s_rdata,
    output logic [1:0]      s_rresp,
    output logic            s_rlast,
    output logic            s_rvalid,
    input  logic            s_rready,
    output logic [31:0]     m_haddr,
    output logic [1:0]      m_htrans,
    output logic [2:0]      m_hsize,
    output logic [2:0]      m_hburst,
    output logic            m_hwrite,
    output logic [31:0]     m_hwdata,
    input  logic [31:0]     m_hrdata,
    input  logic            m_hready,
    input  logic [1:0]      m_hresp
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_W_DATA = 3'd1;
    localparam logic [2:0] S_W_ADDR = 3'd2;
    localparam logic [2:0] S_W_DPH  = 3'd3;
    localparam logic [2:0] S_B_RESP = 3'd4;
    localparam logic [2:0] S_R_ADDR = 3'd5;
    localparam logic [2:0] S_R_DPH  = 3'd6;
    localparam logic [2:0] S_R_RESP = 3'd7;

    localparam logic [1:0] c_htrans_idle   = 2'b00;
    localparam logic [1:0] c_htrans_nonseq = 2'b10;
    localparam logic [1:0] c_resp_okay     = 2'b00;
    localparam logic [1:0] c_resp_slverr   = 2'b10;

    logic [2:0]      r_state;
    logic [ID_W-1:0] r_id;
    logic [31:0]     r_addr;
    logic [7:0]      r_len;
    logic [2:0]      r_size;
    logic            r_fixed;
    logic            r_unsup;
    logic [7:0]      r_count;
    logic            r_err;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic [1:0]      r_rresp;
    logic            r_rlast;
    logic            r_last_grant_rd;

    logic            w_grant_wr;
    logic            w_grant_rd;
    logic            w_aw_unsup;
    logic            w_ar_unsup;
    logic            w_last;
    logic            w_addr_phase;
    logic [31:0]     w_next_addr;
    logic            w_unused;

    // Strobes and wlast carry no information here: hsize selects lanes and
    // the latched length decides where the burst ends.
    assign w_unused = ^{s_wstrb, s_wlast};

    // Round-robin: a lone request always wins; on a tie the channel that was
    // not served last goes first.
    assign w_grant_wr = s_awvalid && (!s_arvalid || r_last_grant_rd);
    assign w_grant_rd = s_arvalid && (!s_awvalid || !r_last_grant_rd);

    // Sizes above a word and WRAP/reserved bursts are answered with SLVERR
    // without touching the AHB side.
    assign w_aw_unsup = (s_awsize > 3'd2) || s_awburst[1];
    assign w_ar_unsup = (s_arsize > 3'd2) || s_arburst[1];

    assign w_last       = (r_count == r_len);
    assign w_addr_phase = ((r_state == S_W_ADDR) || (r_state == S_R_ADDR)) && !r_unsup;
    assign w_next_addr  = r_fixed ? r_addr : (r_addr + (32'd1 << r_size));

    assign s_awready = (r_state == S_IDLE) && w_grant_wr;
    assign s_arready = (r_state == S_IDLE) && w_grant_rd;
    assign s_wready  = (r_state == S_W_DATA);
    assign s_bvalid  = (r_state == S_B_RESP);
    assign s_bid     = r_id;
    assign s_bresp   = r_err ? c_resp_slverr : c_resp_okay;
    assign s_rvalid  = (r_state == S_R_RESP);
    assign s_rid     = r_id;
    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;
    assign s_rlast   = r_rlast;

    assign m_htrans = w_addr_phase ? c_htrans_nonseq : c_htrans_idle;
    assign m_haddr  = r_addr & ADDR_MASK;
    assign m_hsize  = r_size;
    assign m_hburst = 3'b000;
    assign m_hwrite = (r_state == S_W_ADDR);
    assign m_hwdata = r_wdata;

    // Bridge sequencer: arbitration, per-beat AHB transfer and AXI response.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state         <= S_IDLE;
            r_id            <= '0;
            r_addr          <= '0;
            r_len           <= '0;
            r_size          <= '0;
            r_fixed         <= 1'b0;
            r_unsup         <= 1'b0;
            r_count         <= '0;
            r_err           <= 1'b0;
            r_wdata         <= '0;
            r_rdata         <= '0;
            r_rresp         <= '0;
            r_rlast         <= 1'b0;
            r_last_grant_rd <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_wr) begin
                        r_id            <= s_awid;
                        r_addr          <= s_awaddr;
                        r_len           <= s_awlen;
                        r_size          <= s_awsize;
                        r_fixed         <= (s_awburst == 2'b00);
                        r_unsup         <= w_aw_unsup;
                        r_count         <= '0;
                        r_err           <= 1'b0;
                        r_last_grant_rd <= 1'b0;
                        r_state         <= S_W_DATA;
                    end else if (w_grant_rd) begin
                        r_id            <= s_arid;
                        r_addr          <= s_araddr;
                        r_len           <= s_arlen;
                        r_size          <= s_arsize;
                        r_fixed         <= (s_arburst == 2'b00);
                        r_unsup         <= w_ar_unsup;
                        r_count         <= '0;
                        r_err           <= 1'b0;
                        r_last_grant_rd <= 1'b1;
                        r_state         <= S_R_ADDR;
                    end
                end
                S_W_DATA: begin
                    if (s_wvalid) begin
                        r_wdata <= s_wdata;
                        if (r_unsup) begin
                            // Drain the beat locally and flag the burst.
                            r_err <= 1'b1;
                            if (w_last) begin
                                r_state <= S_B_RESP;
                            end else begin
                                r_count <= r_count + 8'd1;
                            end
                        end else begin
                            r_state <= S_W_ADDR;
                        end
                    end
                end
                S_W_ADDR: begin
                    if (m_hready) begin
                        r_state <= S_W_DPH;
                    end
                end
                S_W_DPH: begin
                    if (m_hready) begin
                        if (m_hresp != 2'b00) begin
                            r_err <= 1'b1;
                        end
                        r_addr <= w_next_addr;
                        if (w_last) begin
                            r_state <= S_B_RESP;
                        end else begin
                            r_count <= r_count + 8'd1;
                            r_state <= S_W_DATA;
                        end
                    end
                end
                S_B_RESP: begin
                    if (s_bready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_R_ADDR: begin
                    if (r_unsup) begin
                        r_rdata <= '0;
                        r_rresp <= c_resp_slverr;
                        r_rlast <= w_last;
                        r_state <= S_R_RESP;
                    end else if (m_hready) begin
                        r_state <= S_R_DPH;
                    end
                end
                S_R_DPH: begin
                    if (m_hready) begin
                        r_rdata <= m_hrdata;
                        r_rresp <= (m_hresp != 2'b00) ? c_resp_slverr : c_resp_okay;
                        r_rlast <= w_last;
                        r_addr  <= w_next_addr;
                        r_state <= S_R_RESP;
                    end
                end
                S_R_RESP: begin
                    if (s_rready) begin
                        if (r_rlast) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_count <= r_count + 8'd1;
                            r_state <= S_R_ADDR;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_ahbl_single_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_ahbl_single_bridge
// Description : Directed self-checking bench for axi_ahbl_single_bridge with
//               a small AHB slave model (hrdata = data-phase address + 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_ahbl_single_bridge;

    localparam int ID_W = 4;

    logic            aclk = 1'b0;
    logic            areset;
    logic [ID_W-1:0] s_awid;
    logic [31:0]     s_awaddr;
    logic [7:0]      s_awlen;
    logic [2:0]      s_awsize;
    logic [1:0]      s_awburst;
    logic            s_awvalid;
    logic            s_awready;
    logic [31:0]     s_wdata;
    logic [3:0]      s_wstrb;
    logic            s_wlast;
    logic            s_wvalid;
    logic            s_wready;
    logic [ID_W-1:0] s_bid;
    logic [1:0]      s_bresp;
    logic            s_bvalid;
    logic            s_bready;
    logic [ID_W-1:0] s_arid;
    logic [31:0]     s_araddr;
    logic [7:0]      s_arlen;
    logic [2:0]      s_arsize;
    logic [1:0]      s_arburst;
    logic            s_arvalid;
    logic            s_arready;
    logic [ID_W-1:0] s_rid;
    logic [31:0]     s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic            s_rvalid;
    logic            s_rready;
    logic [31:0]     m_haddr;
    logic [1:0]      m_htrans;
    logic [2:0]      m_hsize;
    logic [2:0]      m_hburst;
    logic            m_hwrite;
    logic [31:0]     m_hwdata;
    logic [31:0]     m_hrdata;
    logic            m_hready;
    logic [1:0]      m_hresp;

    int checks = 0;
    int errors = 0;

    // AHB slave model state
    logic        hready_tb = 1'b1;
    int          err_idx   = -1;
    int          n_addr    = 0;
    int          nonseq_seen = 0;
    int          dph_idx   = 0;
    logic        dph_valid = 1'b0;
    logic        dph_write = 1'b0;
    logic [31:0] dph_addr  = 32'h0;
    logic [31:0] addr_log  [64];
    logic        wr_log    [64];
    logic [31:0] wdata_log [64];

    axi_ahbl_single_bridge #(.ID_W(ID_W), .ADDR_MASK(32'hFFFF_FFFF)) dut (
        .aclk(aclk), .areset(areset),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hsize(m_hsize), .m_hburst(m_hburst),
        .m_hwrite(m_hwrite), .m_hwdata(m_hwdata), .m_hrdata(m_hrdata),
        .m_hready(m_hready), .m_hresp(m_hresp)
    );

    always #5 aclk = ~aclk;

    assign m_hready = hready_tb;
    assign m_hrdata = dph_addr + 32'd1;
    assign m_hresp  = (dph_valid && (dph_idx == err_idx)) ? 2'b01 : 2'b00;

    // Slave model: log every accepted address phase and its write data.
    always @(posedge aclk) begin
        if (areset) begin
            dph_valid <= 1'b0;
        end else begin
            if (m_htrans == 2'b10) nonseq_seen <= nonseq_seen + 1;
            if (dph_valid && m_hready && dph_write) wdata_log[dph_idx] <= m_hwdata;
            if (m_hready) begin
                if (m_htrans == 2'b10) begin
                    addr_log[n_addr] <= m_haddr;
                    wr_log[n_addr]   <= m_hwrite;
                    dph_valid        <= 1'b1;
                    dph_addr         <= m_haddr;
                    dph_write        <= m_hwrite;
                    dph_idx          <= n_addr;
                    n_addr           <= n_addr + 1;
                end else begin
                    dph_valid <= 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time exceeded");
        $fatal(1);
    end

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset;
        areset = 1'b1;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arvalid = 1'b0;
        s_rready = 1'b0;
        hready_tb = 1'b1;
        err_idx = -1;
        repeat (3) tick;
        areset = 1'b0;
    endtask

    task automatic do_aw(input logic [ID_W-1:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst;
        s_awvalid = 1'b1;
        #1;
        for (int i = 0; i < 50 && s_awready !== 1'b1; i++) tick;
        checks++;
        if (s_awready !== 1'b1) begin
            errors++;
            $display("FAIL aw_handshake_timeout: awready=%b required 1", s_awready);
        end
        tick;
        s_awvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [ID_W-1:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
        s_arvalid = 1'b1;
        #1;
        for (int i = 0; i < 50 && s_arready !== 1'b1; i++) tick;
        checks++;
        if (s_arready !== 1'b1) begin
            errors++;
            $display("FAIL ar_handshake_timeout: arready=%b required 1", s_arready);
        end
        tick;
        s_arvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] data);
        s_wdata = data; s_wstrb = 4'hF; s_wvalid = 1'b1;
        #1;
        for (int i = 0; i < 50 && s_wready !== 1'b1; i++) tick;
        checks++;
        if (s_wready !== 1'b1) begin
            errors++;
            $display("FAIL w_handshake_timeout: wready=%b required 1", s_wready);
        end
        tick;
        s_wvalid = 1'b0;
    endtask

    task automatic do_b(output logic [1:0] resp, output logic [ID_W-1:0] id);
        s_bready = 1'b1;
        #1;
        for (int i = 0; i < 50 && s_bvalid !== 1'b1; i++) tick;
        checks++;
        if (s_bvalid !== 1'b1) begin
            errors++;
            $display("FAIL b_handshake_timeout: bvalid=%b required 1", s_bvalid);
        end
        resp = s_bresp;
        id   = s_bid;
        tick;
        s_bready = 1'b0;
    endtask

    task automatic do_r(output logic [31:0] data, output logic [1:0] resp,
                        output logic last, output logic [ID_W-1:0] id);
        s_rready = 1'b1;
        #1;
        for (int i = 0; i < 50 && s_rvalid !== 1'b1; i++) tick;
        checks++;
        if (s_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL r_handshake_timeout: rvalid=%b required 1", s_rvalid);
        end
        data = s_rdata; resp = s_rresp; last = s_rlast; id = s_rid;
        tick;
        s_rready = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_handshakes: aw/w/b/ar/r=%b required 00000",
                     {s_awready, s_wready, s_bvalid, s_arready, s_rvalid});
        end
        checks++;
        if (m_htrans !== 2'b00 || m_hwrite !== 1'b0 || m_haddr !== 32'h0 ||
            m_hsize !== 3'b0 || m_hburst !== 3'b0 || m_hwdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_ahb: htrans=%h hwrite=%b haddr=%h hsize=%h hburst=%h hwdata=%h required all 0",
                     m_htrans, m_hwrite, m_haddr, m_hsize, m_hburst, m_hwdata);
        end
        checks++;
        if (s_bid !== '0 || s_bresp !== 2'b0 || s_rid !== '0 || s_rdata !== 32'h0 ||
            s_rresp !== 2'b0 || s_rlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp: bid=%h bresp=%h rid=%h rdata=%h rresp=%h rlast=%b required all 0",
                     s_bid, s_bresp, s_rid, s_rdata, s_rresp, s_rlast);
        end
    endtask

    // Exact-cycle single write with zero wait states.
    task automatic test_single_write;
        s_awid = 4'h5; s_awaddr = 32'h10; s_awlen = 8'd0; s_awsize = 3'd2; s_awburst = 2'd1;
        s_awvalid = 1'b1;
        s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_wlast = 1'b1; s_wvalid = 1'b1;
        #1;
        checks++;
        if (s_awready !== 1'b1) begin
            errors++;
            $display("FAIL sw_awready: got %b required 1", s_awready);
        end
        tick;
        s_awvalid = 1'b0;
        checks++;
        if (s_wready !== 1'b1) begin
            errors++;
            $display("FAIL sw_wready: got %b required 1", s_wready);
        end
        tick;
        s_wvalid = 1'b0;
        checks++;
        if (m_htrans !== 2'b10 || m_haddr !== 32'h10 || m_hwrite !== 1'b1 || m_hsize !== 3'd2 || m_hburst !== 3'd0) begin
            errors++;
            $display("FAIL sw_addr_phase: htrans=%h haddr=%h hwrite=%b hsize=%h hburst=%h required 2/00000010/1/2/0",
                     m_htrans, m_haddr, m_hwrite, m_hsize, m_hburst);
        end
        tick;
        checks++;
        if (m_htrans !== 2'b00 || m_hwdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_data_phase: htrans=%h hwdata=%h required 0/deadbeef", m_htrans, m_hwdata);
        end
        tick;
        checks++;
        if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || s_bid !== 4'h5) begin
            errors++;
            $display("FAIL sw_bresp: bvalid=%b bresp=%h bid=%h required 1/0/5", s_bvalid, s_bresp, s_bid);
        end
        s_bready = 1'b1;
        tick;
        s_bready = 1'b0;
        checks++;
        if (s_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL sw_b_done: bvalid=%b required 0", s_bvalid);
        end
    endtask

    task automatic test_read_incr;
        logic [31:0]     d;
        logic [1:0]      rr;
        logic            l;
        logic [ID_W-1:0] id;
        int n0;
        n0 = n_addr;
        do_ar(4'h3, 32'h100, 8'd3, 3'd2, 2'd1);
        for (int b = 0; b < 4; b++) begin
            do_r(d, rr, l, id);
            checks++;
            if (d !== 32'h101 + 32'(4 * b) || rr !== 2'b00 || l !== (b == 3) || id !== 4'h3) begin
                errors++;
                $display("FAIL rd_incr_beat%0d: rdata=%h rresp=%h rlast=%b rid=%h required %h/0/%b/3",
                         b, d, rr, l, id, 32'h101 + 32'(4 * b), (b == 3));
            end
        end
        checks++;
        if (n_addr - n0 != 4) begin
            errors++;
            $display("FAIL rd_incr_count: transfers=%0d required 4", n_addr - n0);
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (addr_log[n0 + b] !== 32'h100 + 32'(4 * b) || wr_log[n0 + b] !== 1'b0) begin
                errors++;
                $display("FAIL rd_incr_haddr%0d: haddr=%h hwrite=%b required %h/0",
                         b, addr_log[n0 + b], wr_log[n0 + b], 32'h100 + 32'(4 * b));
            end
        end
    endtask

    task automatic test_stall;
        logic [1:0]      rr;
        logic [ID_W-1:0] id;
        logic [31:0]     d;
        logic            l;
        do_aw(4'h1, 32'h200, 8'd0, 3'd2, 2'd1);
        hready_tb = 1'b0;
        s_wdata = 32'hA5A5_0001; s_wvalid = 1'b1;
        #1;
        for (int i = 0; i < 20 && s_wready !== 1'b1; i++) tick;
        tick;
        s_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_htrans !== 2'b10 || m_haddr !== 32'h200 || m_hwrite !== 1'b1) begin
                errors++;
                $display("FAIL stall_addr%0d: htrans=%h haddr=%h hwrite=%b required 2/00000200/1",
                         i, m_htrans, m_haddr, m_hwrite);
            end
            tick;
        end
        hready_tb = 1'b1;
        tick;
        hready_tb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_htrans !== 2'b00 || m_hwdata !== 32'hA5A5_0001 || s_bvalid !== 1'b0) begin
                errors++;
                $display("FAIL stall_data%0d: htrans=%h hwdata=%h bvalid=%b required 0/a5a50001/0",
                         i, m_htrans, m_hwdata, s_bvalid);
            end
            tick;
        end
        hready_tb = 1'b1;
        do_b(rr, id);
        checks++;
        if (rr !== 2'b00 || id !== 4'h1) begin
            errors++;
            $display("FAIL stall_bresp: bresp=%h bid=%h required 0/1", rr, id);
        end
        // Read response back-pressure.
        s_araddr = 32'h300; s_arid = 4'h2; s_arlen = 8'd0; s_arsize = 3'd2; s_arburst = 2'd1;
        do_ar(4'h2, 32'h300, 8'd0, 3'd2, 2'd1);
        for (int i = 0; i < 20 && s_rvalid !== 1'b1; i++) tick;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (s_rvalid !== 1'b1 || s_rdata !== 32'h301 || s_rlast !== 1'b1) begin
                errors++;
                $display("FAIL stall_rvalid%0d: rvalid=%b rdata=%h rlast=%b required 1/00000301/1",
                         i, s_rvalid, s_rdata, s_rlast);
            end
            tick;
        end
        do_r(d, rr, l, id);
        checks++;
        if (d !== 32'h301 || rr !== 2'b00 || id !== 4'h2) begin
            errors++;
            $display("FAIL stall_rdata: rdata=%h rresp=%h rid=%h required 00000301/0/2", d, rr, id);
        end
    endtask

    task automatic test_write_error;
        logic [1:0]      rr;
        logic [ID_W-1:0] id;
        int n0;
        n0 = n_addr;
        err_idx = n0 + 1;
        do_aw(4'h7, 32'h400, 8'd2, 3'd2, 2'd1);
        do_w(32'h1111_1111);
        do_w(32'h2222_2222);
        do_w(32'h3333_3333);
        do_b(rr, id);
        err_idx = -1;
        checks++;
        if (rr !== 2'b10 || id !== 4'h7) begin
            errors++;
            $display("FAIL werr_bresp: bresp=%h bid=%h required 2/7", rr, id);
        end
        checks++;
        if (n_addr - n0 != 3) begin
            errors++;
            $display("FAIL werr_count: transfers=%0d required 3", n_addr - n0);
        end
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (addr_log[n0 + b] !== 32'h400 + 32'(4 * b) || wr_log[n0 + b] !== 1'b1 ||
                wdata_log[n0 + b] !== 32'h1111_1111 * 32'(b + 1)) begin
                errors++;
                $display("FAIL werr_beat%0d: haddr=%h hwrite=%b hwdata=%h required %h/1/%h",
                         b, addr_log[n0 + b], wr_log[n0 + b], wdata_log[n0 + b],
                         32'h400 + 32'(4 * b), 32'h1111_1111 * 32'(b + 1));
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0]      rr;
        logic [ID_W-1:0] id;
        logic [31:0]     d;
        logic            l;
        do_reset();
        s_awid = 4'h4; s_awaddr = 32'h800; s_awlen = 8'd0; s_awsize = 3'd2; s_awburst = 2'd1;
        s_arid = 4'h9; s_araddr = 32'h900; s_arlen = 8'd0; s_arsize = 3'd2; s_arburst = 2'd1;
        s_awvalid = 1'b1; s_arvalid = 1'b1;
        #1;
        checks++;
        if (s_awready !== 1'b1 || s_arready !== 1'b0) begin
            errors++;
            $display("FAIL arb_first: awready=%b arready=%b required 1/0", s_awready, s_arready);
        end
        tick;
        s_awvalid = 1'b0; s_arvalid = 1'b0;
        do_w(32'hCAFE_0001);
        do_b(rr, id);
        checks++;
        if (rr !== 2'b00 || id !== 4'h4) begin
            errors++;
            $display("FAIL arb_wr_b: bresp=%h bid=%h required 0/4", rr, id);
        end
        s_awvalid = 1'b1; s_arvalid = 1'b1;
        #1;
        checks++;
        if (s_arready !== 1'b1 || s_awready !== 1'b0) begin
            errors++;
            $display("FAIL arb_second: arready=%b awready=%b required 1/0", s_arready, s_awready);
        end
        tick;
        s_arvalid = 1'b0;
        do_r(d, rr, l, id);
        checks++;
        if (d !== 32'h901 || rr !== 2'b00 || l !== 1'b1 || id !== 4'h9) begin
            errors++;
            $display("FAIL arb_rd: rdata=%h rresp=%h rlast=%b rid=%h required 00000901/0/1/9", d, rr, l, id);
        end
        do_aw(4'h4, 32'h800, 8'd0, 3'd2, 2'd1);
        do_w(32'hCAFE_0002);
        do_b(rr, id);
        checks++;
        if (rr !== 2'b00 || id !== 4'h4) begin
            errors++;
            $display("FAIL arb_wr2_b: bresp=%h bid=%h required 0/4", rr, id);
        end
    endtask

    task automatic test_unsupported;
        logic [1:0]      rr;
        logic [ID_W-1:0] id;
        logic [31:0]     d;
        logic            l;
        int s0;
        s0 = nonseq_seen;
        do_aw(4'h5, 32'h500, 8'd1, 3'd2, 2'd2);
        do_w(32'h5555_0001);
        do_w(32'h5555_0002);
        checks++;
        if (s_wready !== 1'b0) begin
            errors++;
            $display("FAIL unsup_wready_after: wready=%b required 0", s_wready);
        end
        do_b(rr, id);
        checks++;
        if (rr !== 2'b10 || id !== 4'h5) begin
            errors++;
            $display("FAIL unsup_bresp: bresp=%h bid=%h required 2/5", rr, id);
        end
        do_ar(4'h6, 32'h600, 8'd0, 3'd3, 2'd1);
        do_r(d, rr, l, id);
        checks++;
        if (d !== 32'h0 || rr !== 2'b10 || l !== 1'b1 || id !== 4'h6) begin
            errors++;
            $display("FAIL unsup_rresp: rdata=%h rresp=%h rlast=%b rid=%h required 0/2/1/6", d, rr, l, id);
        end
        checks++;
        if (nonseq_seen != s0) begin
            errors++;
            $display("FAIL unsup_no_ahb: nonseq cycles=%0d required 0", nonseq_seen - s0);
        end
    endtask

    task automatic test_fixed;
        logic [1:0]      rr;
        logic [ID_W-1:0] id;
        logic [31:0]     d;
        logic            l;
        int n0;
        n0 = n_addr;
        do_ar(4'h1, 32'h700, 8'd1, 3'd2, 2'd0);
        for (int b = 0; b < 2; b++) begin
            do_r(d, rr, l, id);
            checks++;
            if (d !== 32'h701 || l !== (b == 1) || addr_log[n0 + b] !== 32'h700) begin
                errors++;
                $display("FAIL fixed_beat%0d: rdata=%h rlast=%b haddr=%h required 00000701/%b/00000700",
                         b, d, l, addr_log[n0 + b], (b == 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_incr();
        test_stall();
        test_write_error();
        test_back_to_back();
        test_unsupported();
        test_fixed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_ahbl_single_bridge.md
Name: axi_ahbl_single_bridge

Overview:
- AXI4 slave to AHB-Lite master bridge that feeds the USB OTG controller's AHB slave register/FIFO port.
- Splits every AXI burst into individual AHB SINGLE NONSEQ transfers.
- Serialises reads and writes with round-robin arbitration and collects AHB error responses into AXI responses.
- Runs on the controller's bus clock; hsel and hready-in on the controller side are tied high outside this block.

Parameters:
ID_W, 4, width of AXI ID fields
ADDR_MASK, 32'hFFFF_FFFF, AND-mask applied to every AHB address before it is driven

Ports:
aclk  in  1  bus clock
areset  in  1  synchronous active-high reset
s_awid  in  ID_W  write ID
s_awaddr  in  32  write start address
s_awlen  in  8  beats minus one
s_awsize  in  3  bytes per beat (log2)
s_awburst  in  2  0=FIXED 1=INCR 2=WRAP
s_awvalid  in  1  AW valid
s_awready  out  1  AW ready
s_wdata  in  32  write data
s_wstrb  in  4  write strobes (ignored; hsize selects lanes)
s_wlast  in  1  last beat (ignored; awlen is authoritative)
s_wvalid  in  1  W valid
s_wready  out  1  W ready
s_bid  out  ID_W  write response ID
s_bresp  out  2  write response
s_bvalid  out  1  B valid
s_bready  in  1  B ready
s_arid  in  ID_W  read ID
s_araddr  in  32  read start address
s_arlen  in  8  beats minus one
s_arsize  in  3  bytes per beat (log2)
s_arburst  in  2  burst type
s_arvalid  in  1  AR valid
s_arready  out  1  AR ready
s_rid  out  ID_W  read ID
s_rdata  out  32  read data
s_rresp  out  2  read response
s_rlast  out  1  last read beat
s_rvalid  out  1  R valid
s_rready  in  1  R ready
m_haddr  out  32  AHB address
m_htrans  out  2  AHB transfer type (IDLE=0, NONSEQ=2 only)
m_hsize  out  3  AHB size
m_hburst  out  3  always 0 (SINGLE)
m_hwrite  out  1  AHB direction
m_hwdata  out  32  AHB write data
m_hrdata  in  32  AHB read data
m_hready  in  1  slave transfer done
m_hresp  in  2  slave response; nonzero = error

Behaviour:
- Clocking and reset: one clock (aclk); reset areset is synchronous, active-high. Reset: FSM to IDLE; all AXI ready/valid outputs 0; m_htrans=0, m_hwrite=0, m_haddr/m_hsize/m_hburst/m_hwdata=0; s_bid/s_bresp/s_rid/s_rdata/s_rresp/s_rlast=0; last_grant=READ. Reset mid-transfer aborts everything; in-flight AHB beats and AXI responses are dropped.
- FSM states: IDLE, W_DATA, W_ADDR, W_DPH, B_RESP, R_ADDR, R_DPH, R_RESP.
- IDLE arbitration:
  - Only one of awvalid/arvalid: accept it.
  - Both: grant the channel not in last_grant.
  - s_awready/s_arready are asserted combinationally in IDLE for the granted channel only.
  - On handshake, latch id, addr, len, size, burst; clear beat counter and error flag; update last_grant.
  - Write -> W_DATA; read -> R_ADDR.
- Unsupported requests (size>2, or burst is WRAP or 3):
  - Issue no AHB activity.
  - Write: s_wready=1 for exactly len+1 beats, then B_RESP with SLVERR.
  - Read: return len+1 beats with rdata=0, rresp=SLVERR.
- W_DATA: s_wready=1; on handshake, latch wdata -> W_ADDR.
- W_ADDR / R_ADDR (address phase):
  - m_htrans=NONSEQ, m_haddr=addr&ADDR_MASK, m_hsize=size, m_hwrite=1 (write) or 0 (read).
  - Held stable while m_hready=0.
  - On m_hready=1 -> W_DPH / R_DPH.
- W_DPH / R_DPH (data phase):
  - m_htrans=IDLE; in W_DPH, m_hwdata=latched data.
  - Wait for m_hready=1, then sample m_hresp; nonzero sets the error flag (writes) or the beat's rresp=SLVERR (reads).
  - R_DPH also captures m_hrdata into s_rdata.
- Address update after each beat: INCR: addr += 1<<size, modulo 2^32, no 4KB check. FIXED: unchanged.
- Beat counting: after W_DPH, last beat (count==len) -> B_RESP, else -> W_DATA.
- B_RESP: s_bvalid=1, s_bid=id, s_bresp=error?2'b10:2'b00; held until s_bready, then -> IDLE.
- R_RESP:
  - s_rvalid=1, s_rid=id, s_rlast=(count==len); held stable until s_rready.
  - Then -> R_ADDR for the next beat, or -> IDLE after the last beat.
- Error handling: an error does not stop a burst; all beats are issued.
- Latency with zero wait states: write beat = 3 cycles (W, addr, data); read beat = 3 cycles plus R handshake.

Test Plan:
- Write 0xDEADBEEF to 0x10, size 2, len 0, hready=1 -> one cycle htrans=2/haddr=0x10/hwrite=1; next cycle hwdata=0xDEADBEEF; bvalid with bresp=0 and bid echoed.
- Read INCR len=3 at 0x100, hrdata=addr+1 -> AHB reads at 0x100, 0x104, 0x108, 0x10C; rdata 0x101..0x10D; rlast only on beat 4.
- hready low 3 cycles in address and data phases; rready low 2 cycles -> haddr/htrans/hwdata stable; rvalid held with stable rdata.
- 3-beat write with hresp=1 on beat 2 -> three NONSEQ transfers issued; bresp=2'b10.
- awvalid and arvalid together after reset -> write served first; next simultaneous pair -> read served first.
- WRAP write len=1, then size=3 read len=0 -> no NONSEQ issued; two W beats accepted, then bresp=SLVERR; one R beat with rresp=SLVERR, rdata=0, rlast=1.
